adder_share_arbiter: RTL and testbench

- Shares one registered WIDTH-bit adder datapath between two requesters.
- Uses round-robin arbitration and a fixed 2-stage pipeline, tagging each result with its requester ID.
- Latency is identical for every operand value: there is deliberately no zero-operand shortcut. This keeps timing independent of operand data, so requester operands can be marked as taint sources and the response as a taint sink.
- Sits between the two operand producers and the result consumer; the consumer always accepts results.

---
 rtl/adder_share_arbiter.sv | 86 ++++++++
 tb/tb_adder_share_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Two requesters share one registered adder. Round-robin arbitration feeds a fixed
// 2-stage pipeline. Latency never depends on operand values, so there is no zero-operand shortcut.
module adder_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_carry,
  output logic [CNT_W-1:0] op_count
);

  logic             rr_ptr;
  logic             s1_valid;
  logic             s1_id;
  logic [WIDTH:0]   s1_sum;

  logic             accept;
  logic             grant_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum_ext;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n) begin
      if (req0_valid && (!req1_valid || !rr_ptr)) req0_ready = 1'b1;
      else if (req1_valid)                        req1_ready = 1'b1;
    end
  end

  assign accept   = req0_ready | req1_ready;
  assign grant_id = req1_ready;
  assign op_a     = grant_id ? req1_a : req0_a;
  assign op_b     = grant_id ? req1_b : req0_b;
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  // NOTE: the data registers are also reset. This keeps the outputs at 0 after reset
  // and keeps stale operands from showing up on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_sum     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        rr_ptr   <= ~grant_id;
        s1_valid <= 1'b1;
        s1_id    <= grant_id;
        s1_sum   <= sum_ext;
        op_count <= op_count + CNT_W'(1);
      end else begin
        s1_valid <= 1'b0;
      end

      // The result fields hold between responses; only resp_valid drops.
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_id    <= s1_id;
        resp_sum   <= s1_sum[WIDTH-1:0];
        resp_carry <= s1_sum[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (WIDTH=4, CNT_W=8).
// Inputs are driven 1 time unit after posedge, and outputs are sampled 1 time unit after that.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_id, resp_carry;
  logic [3:0] resp_sum;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_carry(resp_carry), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Runs one uncontended op and checks ready, the t+1 gap, the t+2 response, and the hold at t+3.
  task automatic single_op(input string tag, input logic id, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] es, input logic ec);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    check({tag, "_ready0"}, req0_ready, !id);
    check({tag, "_ready1"}, req1_ready, id);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_no_early_resp"}, resp_valid, 1'b0);
    tick();
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_resp_id"},    resp_id,    id);
    check({tag, "_resp_sum"},   resp_sum,   es);
    check({tag, "_resp_carry"}, resp_carry, ec);
    tick();
    check({tag, "_resp_drop"},  resp_valid, 1'b0);
    check({tag, "_sum_hold"},   resp_sum,   es);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick();
    tick();

    // Reset state; ready stays low while reset is asserted, even with a valid request.
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_sum", resp_sum, 4'h0);
    check("rst_op_count", op_count, 8'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Basic op: 3 + 4 = 7.
    single_op("basic", 1'b0, 4'd3, 4'd4, 4'd7, 1'b0);
    check("basic_op_count", op_count, 8'd1);

    // Continuous contention after reset: grants alternate 0,1,0,1 and responses follow 2 cycles later.
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (i < 4) begin
        check($sformatf("rr_ready0_%0d", i), req0_ready, (i % 2) == 0);
        check($sformatf("rr_ready1_%0d", i), req1_ready, (i % 2) == 1);
      end
      if (i >= 2) begin
        check($sformatf("rr_resp_valid_%0d", i), resp_valid, 1'b1);
        check($sformatf("rr_resp_id_%0d", i), resp_id, (i % 2) == 1);
        check($sformatf("rr_resp_sum_%0d", i), resp_sum, ((i % 2) == 1) ? 4'd4 : 4'd2);
      end
      tick();
    end
    check("rr_resp_end", resp_valid, 1'b0);
    check("rr_op_count", op_count, 8'd4);

    // A zero-operand op and a nonzero op must take the same latency.
    single_op("zero_ops", 1'b1, 4'd0, 4'd0, 4'd0,  1'b0);
    single_op("nine_five", 1'b1, 4'd9, 4'd5, 4'd14, 1'b0);

    // Overflow: F + 1 wraps to 0 with carry out.
    single_op("overflow", 1'b0, 4'hF, 4'h1, 4'h0, 1'b1);

    // Reset while an op is in stage 1: it is discarded, and requester 0 wins the next contention.
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_carry", resp_carry, 1'b0);
    check("midrst_resp_sum", resp_sum, 4'h0);
    check("midrst_op_count", op_count, 8'd0);
    tick();
    check("midrst_no_late_resp", resp_valid, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midrst_prio_ready0", req0_ready, 1'b1);
    check("midrst_prio_ready1", req1_ready, 1'b0);
    tick();
    req1_valid = 1'b0;

    // 256 accepts wrap the 8-bit counter back to 0.
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("cnt_255", op_count, 8'd255);
    tick();
    req0_valid = 1'b0;
    check("cnt_wrap", op_count, 8'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
